// File: rtl/spi_mem_slave.sv
// SPI mode-0 slave giving a host word-level read/write access to a memory port.
// Optional build macro SPI_MEM_STATUS_EN adds the status-read command 0x05.
module spi_mem_slave #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sclk,
    input  logic              cs_n,
    input  logic              mosi,
    output logic              miso,
    output logic              miso_oe,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);
    localparam int CNT_MAX = (DATA_W > 16) ? DATA_W : 16;
    localparam int CNT_W   = $clog2(CNT_MAX);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_CMD    = 3'd1;
    localparam logic [2:0] ST_ADDR   = 3'd2;
    localparam logic [2:0] ST_WDATA  = 3'd3;
    localparam logic [2:0] ST_RDATA  = 3'd4;
    localparam logic [2:0] ST_IGNORE = 3'd5;
`ifdef SPI_MEM_STATUS_EN
    localparam logic [2:0] ST_STATUS = 3'd6;
`endif

    logic [2:0] sclk_sync_q;
    logic [1:0] cs_sync_q;
    logic [1:0] mosi_sync_q;
    logic       sclk_rise;
    logic       sclk_fall;
    logic       cs_hi;
    logic       mosi_s;

    // cs_n synchronizer resets to deselected so the FSM stays idle out of reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sclk_sync_q <= '0;
            cs_sync_q   <= 2'b11;
            mosi_sync_q <= '0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[1:0], sclk};
            cs_sync_q   <= {cs_sync_q[0], cs_n};
            mosi_sync_q <= {mosi_sync_q[0], mosi};
        end
    end

    assign sclk_rise = sclk_sync_q[1] & ~sclk_sync_q[2];
    assign sclk_fall = ~sclk_sync_q[1] & sclk_sync_q[2];
    assign cs_hi     = cs_sync_q[1];
    assign mosi_s    = mosi_sync_q[1];

    logic [2:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [7:0]        cmd_q, cmd_d;
    logic [DATA_W-2:0] rx_q, rx_d;
    logic [DATA_W-1:0] tx_q, tx_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              we_q, we_d;
    logic              re_q, re_d;
    logic              cap_q, cap_d;
    logic              ld_q, ld_d;
    logic              miso_q, miso_d;
`ifdef SPI_MEM_STATUS_EN
    logic [15:0]       wr_cnt_q, wr_cnt_d;
    logic [31:0]       stat_w;
    assign stat_w = {wr_cnt_q, 8'hA5, 8'(ADDR_W)};
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cmd_d   = cmd_q;
        rx_d    = rx_q;
        tx_d    = tx_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = 1'b0;
        re_d    = 1'b0;
        cap_d   = re_q;
        ld_d    = cap_q;
        rdata_d = cap_q ? mem_rdata : rdata_q;
        miso_d  = miso_q;
`ifdef SPI_MEM_STATUS_EN
        wr_cnt_d = wr_cnt_q;
        if (we_q && wr_cnt_q != 16'hFFFF) wr_cnt_d = wr_cnt_q + 16'd1;
`endif
        if (we_q) addr_d = addr_q + ADDR_W'(1);
        if (sclk_rise) rx_d = {rx_q[DATA_W-3:0], mosi_s};
        // Prefetched read word: mem_re at T, captured at T+1, loaded here at T+2.
        if (ld_q) tx_d = rdata_q;

        case (state_q)
            ST_IDLE: begin
                cnt_d  = '0;
                miso_d = 1'b0;
                if (!cs_hi) state_d = ST_CMD;
            end
            ST_CMD: begin
                if (sclk_rise) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(7)) begin
                        cnt_d = '0;
                        cmd_d = {rx_q[6:0], mosi_s};
                        if (cmd_d == 8'h02 || cmd_d == 8'h03) begin
                            state_d = ST_ADDR;
`ifdef SPI_MEM_STATUS_EN
                        end else if (cmd_d == 8'h05) begin
                            state_d = ST_STATUS;
                            tx_d    = DATA_W'(stat_w);
`endif
                        end else begin
                            state_d = ST_IGNORE;
                        end
                    end
                end
            end
            ST_ADDR: begin
                if (sclk_rise) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(15)) begin
                        cnt_d  = '0;
                        addr_d = {rx_q[ADDR_W-2:0], mosi_s};
                        if (cmd_q == 8'h03) begin
                            state_d = ST_RDATA;
                            re_d    = 1'b1;
                        end else begin
                            state_d = ST_WDATA;
                        end
                    end
                end
            end
            ST_WDATA: begin
                if (sclk_rise) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(DATA_W-1)) begin
                        cnt_d   = '0;
                        we_d    = 1'b1;
                        wdata_d = {rx_q, mosi_s};
                    end
                end
            end
            ST_RDATA: begin
                if (sclk_fall) begin
                    miso_d = tx_q[DATA_W-1];
                    tx_d   = {tx_q[DATA_W-2:0], 1'b0};
                end
                if (sclk_rise) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(DATA_W-1)) begin
                        cnt_d  = '0;
                        addr_d = addr_q + ADDR_W'(1);
                        re_d   = 1'b1;
                    end
                end
            end
`ifdef SPI_MEM_STATUS_EN
            ST_STATUS: begin
                if (sclk_fall) begin
                    miso_d = tx_q[DATA_W-1];
                    tx_d   = {tx_q[DATA_W-2:0], 1'b0};
                end
                if (sclk_rise) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(DATA_W-1)) begin
                        cnt_d   = '0;
                        state_d = ST_IGNORE;
                    end
                end
            end
`endif
            ST_IGNORE: ;
            default: state_d = ST_IDLE;
        endcase

        // Deselect aborts the frame, but a write strobe for a completed word still issues.
        if (cs_hi) begin
            state_d = ST_IDLE;
            re_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            cmd_q    <= '0;
            rx_q     <= '0;
            tx_q     <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            we_q     <= 1'b0;
            re_q     <= 1'b0;
            cap_q    <= 1'b0;
            ld_q     <= 1'b0;
            miso_q   <= 1'b0;
`ifdef SPI_MEM_STATUS_EN
            wr_cnt_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            cmd_q    <= cmd_d;
            rx_q     <= rx_d;
            tx_q     <= tx_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            we_q     <= we_d;
            re_q     <= re_d;
            cap_q    <= cap_d;
            ld_q     <= ld_d;
            miso_q   <= miso_d;
`ifdef SPI_MEM_STATUS_EN
            wr_cnt_q <= wr_cnt_d;
`endif
        end
    end

`ifdef SPI_MEM_STATUS_EN
    assign miso_oe = (state_q == ST_RDATA) || (state_q == ST_STATUS);
`else
    assign miso_oe = (state_q == ST_RDATA);
`endif
    assign miso      = miso_oe & miso_q;
    assign busy      = (state_q != ST_IDLE);
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_we    = we_q;
    assign mem_re    = re_q;

endmodule

// File: tb/tb_spi_mem_slave.sv
// Directed bench for spi_mem_slave: host-side SPI tasks plus a 4K-word memory model.
module tb_spi_mem_slave;
    localparam int ADDR_W = 12;
    localparam int DATA_W = 32;
    localparam int HALF   = 8;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              sclk = 1'b0;
    logic              cs_n = 1'b1;
    logic              mosi = 1'b0;
    logic              miso;
    logic              miso_oe;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic              mem_re;
    logic [DATA_W-1:0] mem_rdata = '0;
    logic              busy;

    int checks = 0;
    int failures = 0;

    logic [31:0] mem [0:4095];
    logic [11:0] wr_addr [0:15];
    logic [31:0] wr_data [0:15];
    int   wr_n = 0;
    int   re_n = 0;
    int   both_n = 0;
    int   miso_bad = 0;
    logic oe_seen = 1'b0;

    spi_mem_slave #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .reset(reset), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
        .miso(miso), .miso_oe(miso_oe), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_re) begin
            mem_rdata <= mem[mem_addr];
            re_n = re_n + 1;
        end
        if (mem_we) begin
            mem[mem_addr] = mem_wdata;
            if (wr_n < 16) begin
                wr_addr[wr_n] = mem_addr;
                wr_data[wr_n] = mem_wdata;
            end
            wr_n = wr_n + 1;
        end
    end

    always @(negedge clk) begin
        if (mem_we && mem_re) both_n = both_n + 1;
        if (!miso_oe && miso) miso_bad = miso_bad + 1;
        if (miso_oe) oe_seen = 1'b1;
    end

    task automatic spi_bit(input logic b, output logic r);
        mosi = b;
        repeat (HALF) @(negedge clk);
        r = miso;
        sclk = 1'b1;
        repeat (HALF) @(negedge clk);
        sclk = 1'b0;
    endtask

    task automatic spi_word(input logic [31:0] v, input int n, output logic [31:0] r);
        logic b;
        r = '0;
        for (int i = n - 1; i >= 0; i--) begin
            spi_bit(v[i], b);
            r = {r[30:0], b};
        end
    endtask

    task automatic cs_low();
        cs_n = 1'b0;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic cs_high();
        cs_n = 1'b1;
        mosi = 1'b0;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic clear_log();
        wr_n = 0;
        re_n = 0;
        oe_seen = 1'b0;
    endtask

    task automatic write_frame(input logic [15:0] a, input logic [31:0] w0,
                               input logic [31:0] w1, input int nwords);
        logic [31:0] r;
        cs_low();
        spi_word(32'h02, 8, r);
        spi_word({16'h0, a}, 16, r);
        spi_word(w0, 32, r);
        if (nwords > 1) spi_word(w1, 32, r);
        cs_high();
    endtask

    task automatic test_reset();
        logic [DATA_W+ADDR_W+4:0] outs;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            sclk = ~sclk;
            mosi = ~mosi;
            cs_n = ~cs_n;
            outs = {miso, miso_oe, mem_we, mem_re, busy, mem_addr, mem_wdata};
            checks++;
            if (outs !== '0) begin
                failures++;
                $display("FAIL reset_outputs cycle=%0d got=%h exp=0", i, outs);
            end
        end
        sclk = 1'b0;
        mosi = 1'b0;
        cs_n = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        repeat (6) @(negedge clk);
        outs = {miso, miso_oe, mem_we, mem_re, busy, mem_addr, mem_wdata};
        checks++;
        if (outs !== '0) begin
            failures++;
            $display("FAIL post_reset_outputs got=%h exp=0", outs);
        end
        checks++;
        if (wr_n != 0 || re_n != 0) begin
            failures++;
            $display("FAIL reset_strobes we=%0d re=%0d exp=0/0", wr_n, re_n);
        end
    endtask

    task automatic test_write_burst();
        logic [31:0] r;
        clear_log();
        cs_low();
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL busy_in_frame got=%b exp=1", busy);
        end
        spi_word(32'h02, 8, r);
        spi_word(32'h0800, 16, r);
        spi_word(32'hDEADBEEF, 32, r);
        spi_word(32'h00000001, 32, r);
        cs_high();
        checks++;
        if (wr_n != 2) begin
            failures++;
            $display("FAIL wr_count got=%0d exp=2", wr_n);
        end
        checks++;
        if (wr_addr[0] !== 12'h800 || wr_data[0] !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL wr0 got=(%h,%h) exp=(800,deadbeef)", wr_addr[0], wr_data[0]);
        end
        checks++;
        if (wr_addr[1] !== 12'h801 || wr_data[1] !== 32'h00000001) begin
            failures++;
            $display("FAIL wr1 got=(%h,%h) exp=(801,00000001)", wr_addr[1], wr_data[1]);
        end
        checks++;
        if (busy !== 1'b0 || re_n != 0) begin
            failures++;
            $display("FAIL write_end busy=%b re=%0d exp=0/0", busy, re_n);
        end
    endtask

    task automatic test_read_burst();
        logic [31:0] r, r0, r1;
        mem[0] = 32'h20080005;
        mem[1] = 32'h8C090000;
        clear_log();
        cs_low();
        spi_word(32'h03, 8, r);
        spi_word(32'h0000, 16, r);
        spi_word(32'h0, 32, r0);
        spi_word(32'h0, 32, r1);
        checks++;
        if (miso_oe !== 1'b1) begin
            failures++;
            $display("FAIL read_oe got=%b exp=1", miso_oe);
        end
        cs_high();
        checks++;
        if (r0 !== 32'h20080005) begin
            failures++;
            $display("FAIL read_word0 got=%h exp=20080005", r0);
        end
        checks++;
        if (r1 !== 32'h8C090000) begin
            failures++;
            $display("FAIL read_word1 got=%h exp=8c090000", r1);
        end
        checks++;
        if (miso_oe !== 1'b0 || miso !== 1'b0 || wr_n != 0) begin
            failures++;
            $display("FAIL read_end oe=%b miso=%b we=%0d exp=0/0/0", miso_oe, miso, wr_n);
        end
    endtask

    task automatic test_wrap();
        clear_log();
        write_frame(16'h0FFF, 32'h11111111, 32'h22222222, 2);
        checks++;
        if (wr_n != 2) begin
            failures++;
            $display("FAIL wrap_count got=%0d exp=2", wr_n);
        end
        checks++;
        if (wr_addr[0] !== 12'hFFF || wr_data[0] !== 32'h11111111) begin
            failures++;
            $display("FAIL wrap_wr0 got=(%h,%h) exp=(fff,11111111)", wr_addr[0], wr_data[0]);
        end
        checks++;
        if (wr_addr[1] !== 12'h000 || wr_data[1] !== 32'h22222222) begin
            failures++;
            $display("FAIL wrap_wr1 got=(%h,%h) exp=(000,22222222)", wr_addr[1], wr_data[1]);
        end
    endtask

    task automatic test_abort();
        logic [31:0] r;
        clear_log();
        cs_low();
        spi_word(32'h02, 8, r);
        spi_word(32'h0100, 16, r);
        spi_word(32'h000ABCDE, 20, r);
        cs_high();
        checks++;
        if (wr_n != 0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL abort_no_write we=%0d busy=%b exp=0/0", wr_n, busy);
        end
        clear_log();
        write_frame(16'h0123, 32'hCAFEF00D, 32'h0, 1);
        checks++;
        if (wr_n != 1) begin
            failures++;
            $display("FAIL abort_next_count got=%0d exp=1", wr_n);
        end
        checks++;
        if (wr_addr[0] !== 12'h123 || wr_data[0] !== 32'hCAFEF00D) begin
            failures++;
            $display("FAIL abort_next_wr got=(%h,%h) exp=(123,cafef00d)", wr_addr[0], wr_data[0]);
        end
    endtask

    task automatic test_unknown_cmd(input logic [7:0] cmd);
        logic [31:0] r;
        clear_log();
        cs_low();
        spi_word({24'h0, cmd}, 8, r);
        spi_word(32'h0000, 16, r);
        spi_word(32'hFFFFFFFF, 32, r);
        cs_high();
        checks++;
        if (wr_n != 0 || re_n != 0) begin
            failures++;
            $display("FAIL unknown_%h_strobes we=%0d re=%0d exp=0/0", cmd, wr_n, re_n);
        end
        checks++;
        if (oe_seen !== 1'b0) begin
            failures++;
            $display("FAIL unknown_%h_oe got=%b exp=0", cmd, oe_seen);
        end
    endtask

    task automatic test_status();
`ifdef SPI_MEM_STATUS_EN
        logic [31:0] r;
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        clear_log();
        write_frame(16'h0200, 32'h1, 32'h2, 2);
        cs_low();
        spi_word(32'h05, 8, r);
        spi_word(32'h0, 32, r);
        cs_high();
        checks++;
        if (r !== 32'h0002A50C) begin
            failures++;
            $display("FAIL status_word got=%h exp=0002a50c", r);
        end
        checks++;
        if (wr_n != 2 || re_n != 0) begin
            failures++;
            $display("FAIL status_strobes we=%0d re=%0d exp=2/0", wr_n, re_n);
        end
`else
        test_unknown_cmd(8'h05);
`endif
    endtask

    task automatic test_back_to_back();
        logic [31:0] r, r0, r1;
        clear_log();
        write_frame(16'h0010, 32'hA5A5A5A5, 32'h5A5A5A5A, 2);
        cs_low();
        spi_word(32'h03, 8, r);
        spi_word(32'h0010, 16, r);
        spi_word(32'h0, 32, r0);
        spi_word(32'h0, 32, r1);
        cs_high();
        checks++;
        if (wr_n != 2) begin
            failures++;
            $display("FAIL b2b_count got=%0d exp=2", wr_n);
        end
        checks++;
        if (r0 !== 32'hA5A5A5A5 || r1 !== 32'h5A5A5A5A) begin
            failures++;
            $display("FAIL b2b_readback got=%h,%h exp=a5a5a5a5,5a5a5a5a", r0, r1);
        end
    endtask

    task automatic test_strobe_rules();
        checks++;
        if (both_n != 0) begin
            failures++;
            $display("FAIL we_re_overlap got=%0d exp=0", both_n);
        end
        checks++;
        if (miso_bad != 0) begin
            failures++;
            $display("FAIL miso_without_oe got=%0d exp=0", miso_bad);
        end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = '0;
        test_reset();
        test_write_burst();
        test_read_burst();
        test_wrap();
        test_abort();
        test_unknown_cmd(8'h7E);
        test_status();
        test_back_to_back();
        test_strobe_rules();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
